// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg: 640x480@60 raster timing constants and the per-axis
// scan phase type shared by the VGA scan generator.
package vga_scan_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {
      VISIBLE = 2'd0,
      FRONT   = 2'd1,
      SYNC    = 2'd2,
      BACK    = 2'd3
   } scan_phase_e;

   // Last count value covered by a span of len counts starting at 0.
   function automatic logic [9:0] last_cnt(input int len);
      return 10'(len - 1);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- a 10-bit position counter and its
// VISIBLE/FRONT/SYNC/BACK phase FSM, both stepping only when adv is high.
module vga_axis_counter
   import vga_scan_pkg::*;
#(
   parameter int VIS_LEN   = H_VISIBLE,
   parameter int FRONT_LEN = H_FRONT,
   parameter int SYNC_LEN  = H_SYNC,
   parameter int BACK_LEN  = H_BACK
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        adv,
   output logic [9:0]  cnt,
   output scan_phase_e phase,
   output logic        wrap
);

   localparam logic [9:0] VIS_END   = last_cnt(VIS_LEN);
   localparam logic [9:0] FRONT_END = last_cnt(VIS_LEN + FRONT_LEN);
   localparam logic [9:0] SYNC_END  =
      last_cnt(VIS_LEN + FRONT_LEN + SYNC_LEN);
   localparam logic [9:0] LAST      =
      last_cnt(VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN);

   logic [9:0]  cnt_q;
   logic        at_last;
   logic        out_of_range;
   scan_phase_e state_q;
   scan_phase_e state_d;

   assign at_last      = (cnt_q == LAST);
   assign out_of_range = (cnt_q > LAST);

   // An unreachable count collapses to 0 on the next advance.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else if (adv) begin
         cnt_q <= (at_last || out_of_range) ? 10'd0 : cnt_q + 10'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= VISIBLE;
      end else if (adv) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (out_of_range) begin
         state_d = VISIBLE;
      end else begin
         unique case (state_q)
            VISIBLE: if (cnt_q == VIS_END)   state_d = FRONT;
            FRONT:   if (cnt_q == FRONT_END) state_d = SYNC;
            SYNC:    if (cnt_q == SYNC_END)  state_d = BACK;
            BACK:    if (at_last)            state_d = VISIBLE;
         endcase
      end
   end

   always_comb begin
      cnt   = cnt_q;
      phase = state_q;
      wrap  = at_last;
   end

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 VGA raster timing -- pixel strobe, syncs, blank,
// DrawX/DrawY. Define VGA_SCAN_FRAME_CNT_EN to build the 16-bit frame counter.
module vga_scan_gen
   import vga_scan_pkg::*;
#(
   parameter int PIX_DIV     = 2,
   parameter int V_VIS_LEN   = V_VISIBLE,
   parameter int V_FRONT_LEN = V_FRONT,
   parameter int V_SYNC_LEN  = V_SYNC,
   parameter int V_BACK_LEN  = V_BACK
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        pixel_clk,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        sync,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   logic        pix_en;
   logic        h_wrap;
   logic        v_wrap;
   logic        v_adv;
   logic        frame_wrap;
   scan_phase_e h_phase;
   scan_phase_e v_phase;

   generate
      if (PIX_DIV == 2) begin : g_div2
         always_ff @(posedge Clk) begin
            if (Reset) pix_en <= 1'b0;
            else       pix_en <= ~pix_en;
         end
      end else if (PIX_DIV == 1) begin : g_div1
         assign pix_en = 1'b1;
      end else begin : g_bad_div
         $error("vga_scan_gen: PIX_DIV must be 1 or 2");
      end
   endgenerate

   vga_axis_counter #(
      .VIS_LEN   (H_VISIBLE),
      .FRONT_LEN (H_FRONT),
      .SYNC_LEN  (H_SYNC),
      .BACK_LEN  (H_BACK)
   ) u_h (
      .Clk   (Clk),
      .Reset (Reset),
      .adv   (pix_en),
      .cnt   (DrawX),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(
      .VIS_LEN   (V_VIS_LEN),
      .FRONT_LEN (V_FRONT_LEN),
      .SYNC_LEN  (V_SYNC_LEN),
      .BACK_LEN  (V_BACK_LEN)
   ) u_v (
      .Clk   (Clk),
      .Reset (Reset),
      .adv   (v_adv),
      .cnt   (DrawY),
      .phase (v_phase),
      .wrap  (v_wrap)
   );

   assign v_adv      = pix_en & h_wrap;
   assign frame_wrap = v_adv & v_wrap;

   // Registered so the pulse lands with the first (0,0) cycle.
   always_ff @(posedge Clk) begin
      if (Reset) frame_start <= 1'b0;
      else       frame_start <= frame_wrap;
   end

`ifdef VGA_SCAN_FRAME_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset)           frame_cnt <= '0;
      else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
   end
`else
   assign frame_cnt = '0;
`endif

   assign pixel_clk = pix_en;
   assign hs        = (h_phase != SYNC);
   assign vs        = (v_phase != SYNC);
   assign blank     = (h_phase == VISIBLE) && (v_phase == VISIBLE);
   assign sync      = 1'b0;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: vector table, hand sequences and random resets checked
// against an arithmetic raster model for three vga_scan_gen builds.
module tb_vga_scan_gen;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #10 Clk = ~Clk;

   typedef struct packed {
      logic        pclk;
      logic        hs;
      logic        vs;
      logic        blank;
      logic        sync;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   // u2: full timing, div 2. u2s/u1: short frame (4/2/2/3 rows).
   logic        pc2, hs2, vs2, bl2, sy2, fs2;
   logic [9:0]  x2, y2;
   logic [15:0] fc2;
   logic        pc2s, hs2s, vs2s, bl2s, sy2s, fs2s;
   logic [9:0]  x2s, y2s;
   logic [15:0] fc2s;
   logic        pc1, hs1, vs1, bl1, sy1, fs1;
   logic [9:0]  x1, y1;
   logic [15:0] fc1;

   vga_scan_gen #(.PIX_DIV(2)) u2 (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pc2), .hs(hs2), .vs(vs2),
      .blank(bl2), .sync(sy2), .DrawX(x2), .DrawY(y2),
      .frame_start(fs2), .frame_cnt(fc2)
   );

   vga_scan_gen #(
      .PIX_DIV(2), .V_VIS_LEN(4), .V_FRONT_LEN(2),
      .V_SYNC_LEN(2), .V_BACK_LEN(3)
   ) u2s (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pc2s), .hs(hs2s), .vs(vs2s),
      .blank(bl2s), .sync(sy2s), .DrawX(x2s), .DrawY(y2s),
      .frame_start(fs2s), .frame_cnt(fc2s)
   );

   vga_scan_gen #(
      .PIX_DIV(1), .V_VIS_LEN(4), .V_FRONT_LEN(2),
      .V_SYNC_LEN(2), .V_BACK_LEN(3)
   ) u1 (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pc1), .hs(hs1), .vs(vs1),
      .blank(bl1), .sync(sy1), .DrawX(x1), .DrawY(y1),
      .frame_start(fs1), .frame_cnt(fc1)
   );

   obs_t a2, a2s, a1;
   assign a2  = {pc2, hs2, vs2, bl2, sy2, x2, y2, fs2, fc2};
   assign a2s = {pc2s, hs2s, vs2s, bl2s, sy2s, x2s, y2s, fs2s, fc2s};
   assign a1  = {pc1, hs1, vs1, bl1, sy1, x1, y1, fs1, fc1};

   // Clk edges since the last edge sampled with Reset high.
   int k = 0;
   always @(posedge Clk) begin
      if (Reset) k <= 0;
      else       k <= k + 1;
   end

   int n_chk = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (k=%0d)", nm, act, exp, k);
   endtask

   function automatic logic [15:0] fc_exp(input int n);
      fc_exp = 16'd0;
`ifdef VGA_SCAN_FRAME_CNT_EN
      fc_exp = 16'(n);
`endif
   endfunction

   // Raster state after kk edges: pixel index p fixes position directly.
   function automatic obs_t model(input int kk, input int div,
                                  input int vvis, input int vfr,
                                  input int vsy, input int vbk);
      obs_t m;
      int p, h, v, vt, ft;
      vt = vvis + vfr + vsy + vbk;
      ft = 800 * vt;
      p  = kk / div;
      h  = p % 800;
      v  = (p / 800) % vt;
      m.pclk  = (div == 1) ? 1'b1 : (kk % 2 == 1);
      m.hs    = !(h >= 656 && h < 752);
      m.vs    = !(v >= vvis + vfr && v < vvis + vfr + vsy);
      m.blank = (h < 640) && (v < vvis);
      m.sync  = 1'b0;
      m.x     = 10'(h);
      m.y     = 10'(v);
      m.fs    = (p > 0) && (p % ft == 0) && (div == 1 || kk % 2 == 0);
      m.fc    = fc_exp(p / ft);
      return m;
   endfunction

   always @(negedge Clk) begin
      if (mon_en) begin
         check("mon_u2",  a2,  model(k, 2, 480, 10, 2, 33));
         check("mon_u2s", a2s, model(k, 2, 4, 2, 2, 3));
         check("mon_u1",  a1,  model(k, 1, 4, 2, 2, 3));
      end
   end

   typedef struct {
      bit         rst;
      int         n;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       pclk;
   } vec_t;

   vec_t tv[12];

   initial begin
      int hs2_low, hs1_low, vs1_low, vs2s_low, pc1_low;
      int fs1_n, fs2s_n, fs2s_k, x0_a, x0_b, blank_bad;
      bit found;

      tv[0]  = '{1'b1, 2,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[1]  = '{1'b0, 1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
      tv[2]  = '{1'b0, 1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[3]  = '{1'b0, 1276, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[4]  = '{1'b0, 2,    10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 30,   10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 2,    10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 190,  10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 2,    10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 94,   10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[10] = '{1'b0, 1,    10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tv[11] = '{1'b0, 1,    10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};

      Reset = 1'b1;
      @(negedge Clk);
      mon_en = 1'b1;

      for (int i = 0; i < 12; i++) begin
         Reset = tv[i].rst;
         repeat (tv[i].n) @(negedge Clk);
         check($sformatf("vec%0d", i),
               {x2, y2, hs2, vs2, bl2, pc2},
               {tv[i].x, tv[i].y, tv[i].hs, tv[i].vs,
                tv[i].blank, tv[i].pclk});
      end

      hs2_low = 0; hs1_low = 0; vs1_low = 0; vs2s_low = 0;
      pc1_low = 0; fs1_n = 0; fs2s_n = 0; fs2s_k = -1;
      x0_a = -1; x0_b = -1; blank_bad = 0;

      // Three short frames on u1, one on u2s.
      for (int c = 0; c < 26400; c++) begin
         @(negedge Clk);
         if (k >= 2000 && k < 3600 && !hs2) hs2_low++;
         if (k >= 2000 && k < 2800 && !hs1) hs1_low++;
         if (k >= 8800 && k < 17600 && !vs1) vs1_low++;
         if (k >= 2000 && k < 19600 && !vs2s) vs2s_low++;
         if (!pc1) pc1_low++;
         if ((y1 >= 10'd4 && bl1) || (y2s >= 10'd4 && bl2s)) blank_bad++;
         if (k >= 2000 && x1 == 10'd0) begin
            if (x0_a < 0)      x0_a = k;
            else if (x0_b < 0) x0_b = k;
         end
         if (fs1) begin
            fs1_n++;
            check("fc_with_fs", fc1, fc_exp(fs1_n));
         end
         if (fs2s) begin
            fs2s_n++;
            fs2s_k = k;
         end
      end

      check("hs_low_div2", hs2_low, 192);
      check("hs_low_div1", hs1_low, 96);
      check("vs_low_div1", vs1_low, 1600);
      check("vs_low_div2", vs2s_low, 3200);
      check("pclk_const_div1", pc1_low, 0);
      check("line_period_div1", x0_b - x0_a, 800);
      check("blank_low_rows", blank_bad, 0);
      check("frame_starts_div1", fs1_n, 3);
      check("frame_starts_div2", fs2s_n, 1);
      check("frame_start_k_div2", fs2s_k, 17600);
      check("frame_cnt_3", fc1, fc_exp(3));

      // Reset in the middle of a vsync row.
      found = 1'b0;
      for (int c = 0; c < 10000 && !found; c++) begin
         @(negedge Clk);
         if (x1 == 10'd700 && y1 == 10'd7) found = 1'b1;
      end
      check("reach_700_7", found, 1);
      check("vs_low_700_7", vs1, 0);
      Reset = 1'b1;
      @(negedge Clk);
      check("rst_mid_u1", {x1, y1, vs1, hs1, fs1, fc1},
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 16'd0});
      check("rst_mid_u2s", {x2s, y2s, vs2s, hs2s, fs2s, fc2s},
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 16'd0});
      Reset = 1'b0;

      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(1, 2500)) @(negedge Clk);
         if ($urandom_range(0, 2) != 0) begin
            Reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
            Reset = 1'b0;
         end
      end
      repeat (5) @(negedge Clk);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
